// File: rtl/edge_pkg.sv
// Shared types and helpers for edge-map consumers: coordinate widths, point record,
// scan FSM states and the {y,x} address packing.
package edge_pkg;

  localparam int unsigned X_W        = 10;
  localparam int unsigned Y_W        = 9;
  localparam int unsigned ADDR_W     = 19;
  localparam int unsigned DEF_WIDTH  = 640;
  localparam int unsigned DEF_HEIGHT = 480;

  typedef struct packed {
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
  } point_t;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain,
    StDone
  } scan_state_e;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [Y_W-1:0] y,
                                                 input logic [X_W-1:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/edge_point_fifo.sv
// Small synchronous FIFO of edge points with flush; head reads as zero when empty.
module edge_point_fifo
  import edge_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  point_t                       i_data,
  input  logic                         i_pop,
  output point_t                       o_data,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  point_t          r_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_push  = i_push && (r_count != CW'(DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/edge_point_extractor.sv
// Scans the edge map in raster order and streams (x,y) of every set pixel, tracking the
// edge count and bounding box; credit-limited reads keep the point FIFO from overflowing.
module edge_point_extractor
  import edge_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned HEIGHT       = DEF_HEIGHT,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_read_addr,
  input  logic              i_read_data,
  output logic              o_point_valid,
  input  logic              i_point_ready,
  output logic [X_W-1:0]    o_point_x,
  output logic [Y_W-1:0]    o_point_y,
  output logic [ADDR_W-1:0] o_edge_count,
  output logic [X_W-1:0]    o_bbox_min_x,
  output logic [X_W-1:0]    o_bbox_max_x,
  output logic [Y_W-1:0]    o_bbox_min_y,
  output logic [Y_W-1:0]    o_bbox_max_y,
  output logic              o_bbox_valid
);

  localparam int unsigned FC_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CR_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
  localparam int unsigned LAST = READ_LATENCY - 1;

  scan_state_e       r_state, w_state_next;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic              r_tag_vld [READ_LATENCY];
  point_t            r_tag_pt  [READ_LATENCY];
  logic [ADDR_W-1:0] r_count;
  logic [X_W-1:0]    r_min_x, r_max_x;
  logic [Y_W-1:0]    r_min_y, r_max_y;
  logic              r_bbox_valid;

  logic [FC_W-1:0]   w_fifo_count;
  logic              w_fifo_empty;
  logic [CR_W-1:0]   w_in_flight;
  logic              w_credit, w_issue, w_last_addr, w_hit, w_pop;
  point_t            w_head, w_ret;

  assign w_ret       = r_tag_pt[LAST];
  assign w_last_addr = (r_x == X_W'(WIDTH - 1)) && (r_y == Y_W'(HEIGHT - 1));
  assign w_credit    = (CR_W'(w_fifo_count) + w_in_flight) < CR_W'(FIFO_DEPTH);
  assign w_issue     = (r_state == StScan) && w_credit && !i_start;
  assign w_hit       = r_tag_vld[LAST] && i_read_data && !i_start;
  assign w_pop       = !w_fifo_empty && i_point_ready;

  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) w_in_flight = w_in_flight + CR_W'(r_tag_vld[i]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (i_start) begin
      w_state_next = StScan;
    end else begin
      case (r_state)
        StIdle:  w_state_next = StIdle;
        StScan:  if (w_issue && w_last_addr) w_state_next = StDrain;
        StDrain: if (w_in_flight == '0 && w_fifo_empty) w_state_next = StDone;
        StDone:  w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x          <= '0;
      r_y          <= '0;
      r_count      <= '0;
      r_min_x      <= '0;
      r_max_x      <= '0;
      r_min_y      <= '0;
      r_max_y      <= '0;
      r_bbox_valid <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_tag_vld[i] <= 1'b0;
        r_tag_pt[i]  <= '0;
      end
    end else if (i_start) begin
      r_x          <= '0;
      r_y          <= '0;
      r_count      <= '0;
      r_min_x      <= '0;
      r_max_x      <= '0;
      r_min_y      <= '0;
      r_max_y      <= '0;
      r_bbox_valid <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) r_tag_vld[i] <= 1'b0;
    end else begin
      // The last address is held, not wrapped, so read_addr never leaves the frame.
      if (w_issue && !w_last_addr) begin
        if (r_x == X_W'(WIDTH - 1)) begin
          r_x <= '0;
          r_y <= r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
      r_tag_vld[0] <= w_issue;
      r_tag_pt[0]  <= {r_y, r_x};
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_pt[i]  <= r_tag_pt[i-1];
      end
      if (w_hit) begin
        if (r_count != '1) r_count <= r_count + 1'b1;
        if (r_count == '0) begin
          r_min_x <= w_ret.x;
          r_max_x <= w_ret.x;
          r_min_y <= w_ret.y;
          r_max_y <= w_ret.y;
        end else begin
          if (w_ret.x < r_min_x) r_min_x <= w_ret.x;
          if (w_ret.x > r_max_x) r_max_x <= w_ret.x;
          if (w_ret.y < r_min_y) r_min_y <= w_ret.y;
          if (w_ret.y > r_max_y) r_max_y <= w_ret.y;
        end
      end
      if (r_state == StDrain && w_state_next == StDone) r_bbox_valid <= (r_count != '0);
    end
  end

  edge_point_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_start),
    .i_push  (w_hit),
    .i_data  (w_ret),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign o_busy        = (r_state == StScan) || (r_state == StDrain);
  assign o_done        = (r_state == StDone) && !i_start;
  assign o_read_addr   = pack_addr(r_y, r_x);
  assign o_point_valid = !w_fifo_empty;
  assign o_point_x     = w_head.x;
  assign o_point_y     = w_head.y;
  assign o_edge_count  = r_count;
  assign o_bbox_min_x  = r_min_x;
  assign o_bbox_max_x  = r_max_x;
  assign o_bbox_min_y  = r_min_y;
  assign o_bbox_max_y  = r_max_y;
  assign o_bbox_valid  = r_bbox_valid;

endmodule

// File: tb/tb_edge_point_extractor.sv
// Bench for edge_point_extractor on an 8x4 frame with a behavioural 2-cycle BRAM and a
// point scoreboard.
module tb_edge_point_extractor;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        point_ready = 1'b0;
  logic        busy, done, read_data, point_valid, bbox_valid;
  logic [18:0] read_addr, edge_count;
  logic [9:0]  point_x, bbox_min_x, bbox_max_x;
  logic [8:0]  point_y, bbox_min_y, bbox_max_y;

  int checks = 0;
  int failures = 0;
  int n_points = 0;
  int n_done = 0;
  logic [18:0] exp_q[$];
  logic [18:0] mon_exp;
  logic [31:0] map_q = '0;
  logic        bram_pipe [LAT];

  always #5 clk = ~clk;

  edge_point_extractor #(
    .WIDTH(W), .HEIGHT(H), .READ_LATENCY(LAT), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy), .o_done(done),
    .o_read_addr(read_addr), .i_read_data(read_data), .o_point_valid(point_valid),
    .i_point_ready(point_ready), .o_point_x(point_x), .o_point_y(point_y),
    .o_edge_count(edge_count), .o_bbox_min_x(bbox_min_x), .o_bbox_max_x(bbox_max_x),
    .o_bbox_min_y(bbox_min_y), .o_bbox_max_y(bbox_max_y), .o_bbox_valid(bbox_valid)
  );

  function automatic logic mem_bit(input logic [18:0] a);
    int y = int'(a[18:10]);
    int x = int'(a[9:0]);
    if (x < W && y < H) return map_q[y*W + x];
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    bram_pipe[0] <= mem_bit(read_addr);
    for (int i = 1; i < LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
  end
  assign read_data = bram_pipe[LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) n_done++;
      if (point_valid && point_ready) begin
        n_points++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_point actual=(%0d,%0d) required=none", point_x, point_y);
        end else begin
          mon_exp = exp_q.pop_front();
          check("point_order", {13'b0, point_y, point_x}, {13'b0, mon_exp});
        end
      end
    end
  end

  task automatic push_expected(input logic [31:0] m);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (m[y*W + x]) exp_q.push_back({9'(y), 10'(x)});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready toggles every cycle.
  task automatic run_to_done(input int mode, input int budget, output int cycles);
    int c = 0;
    bit got = 1'b0;
    while (c < budget && !got) begin
      @(posedge clk); #1;
      point_ready = (mode == 1) ? ~point_ready : 1'b1;
      @(negedge clk);
      c++;
      if (done) got = 1'b1;
    end
    cycles = c;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done required=done_within_%0d", budget);
    end
    #1;
  endtask

  typedef struct {
    logic [31:0] map;
    int          mode;
    int          cnt;
    logic        bv;
    int          minx, maxx, miny, maxy;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int cyc, p0, d0;
    vecs[0] = '{32'h0100_0880, 0, 3, 1'b1, 0, 7, 0, 3};  // (7,0),(3,1),(0,3)
    vecs[1] = '{32'hFFFF_FFFF, 1, 32, 1'b1, 0, 7, 0, 3};
    vecs[2] = '{32'h0010_0400, 0, 2, 1'b1, 2, 4, 1, 2};  // (2,1),(4,2)
    vecs[3] = '{32'h0000_0000, 0, 0, 1'b0, 0, 0, 0, 0};

    #22;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_addr", {13'b0, read_addr}, 0);
    check("rst_pvalid", {31'b0, point_valid}, 0);
    check("rst_count", {13'b0, edge_count}, 0);
    check("rst_bbox_valid", {31'b0, bbox_valid}, 0);
    #1 rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      map_q = vecs[v].map;
      exp_q.delete();
      push_expected(vecs[v].map);
      p0 = n_points;
      d0 = n_done;
      pulse_start();
      run_to_done(vecs[v].mode, 300, cyc);
      check("count", {13'b0, edge_count}, 32'(vecs[v].cnt));
      check("bbox_valid", {31'b0, bbox_valid}, {31'b0, vecs[v].bv});
      check("bbox_min_x", {22'b0, bbox_min_x}, 32'(vecs[v].minx));
      check("bbox_max_x", {22'b0, bbox_max_x}, 32'(vecs[v].maxx));
      check("bbox_min_y", {23'b0, bbox_min_y}, 32'(vecs[v].miny));
      check("bbox_max_y", {23'b0, bbox_max_y}, 32'(vecs[v].maxy));
      check("busy_at_done", {31'b0, busy}, 0);
      check("points_seen", 32'(n_points - p0), 32'(vecs[v].cnt));
      check("queue_left", 32'(exp_q.size()), 0);
      check("done_pulses", 32'(n_done - d0), 1);
      if (vecs[v].cnt == 0) check("empty_latency", {31'b0, cyc >= 33 && cyc <= 40}, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("done_one_cycle", {31'b0, done}, 0);
      check("bbox_valid_hold", {31'b0, bbox_valid}, {31'b0, vecs[v].bv});
    end

    // Single pixel held under backpressure.
    map_q = 32'(1) << (2*W + 5);
    exp_q.delete();
    push_expected(map_q);
    point_ready = 1'b0;
    d0 = n_done;
    pulse_start();
    repeat (100) @(negedge clk);
    #1;
    check("held_valid", {31'b0, point_valid}, 1);
    check("held_x", {22'b0, point_x}, 5);
    check("held_y", {23'b0, point_y}, 2);
    check("held_no_done", 32'(n_done - d0), 0);
    check("held_busy", {31'b0, busy}, 1);
    run_to_done(0, 50, cyc);
    check("held_done", 32'(n_done - d0), 1);
    check("held_queue", 32'(exp_q.size()), 0);
    check("held_bbox", {bbox_min_x[7:0], bbox_max_x[7:0], 7'b0, bbox_min_y, 8'(bbox_max_y)},
          {8'd5, 8'd5, 7'b0, 9'd2, 8'd2});

    // Restart mid-scan with a full FIFO.
    map_q = 32'hFFFF_FFFF;
    exp_q.delete();
    point_ready = 1'b0;
    pulse_start();
    repeat (9) @(posedge clk);
    #1;
    check("pre_restart_addr_nonzero", {31'b0, read_addr != 19'd0}, 1);
    d0 = n_done;
    p0 = n_points;
    push_expected(map_q);
    pulse_start();
    check("restart_addr", {13'b0, read_addr}, 0);
    check("restart_flushed", {31'b0, point_valid}, 0);
    check("restart_count", {13'b0, edge_count}, 0);
    run_to_done(0, 300, cyc);
    check("restart_points", 32'(n_points - p0), 32);
    check("restart_single_done", 32'(n_done - d0), 1);
    check("restart_queue", 32'(exp_q.size()), 0);

    // Asynchronous reset between clock edges.
    map_q = 32'hFFFF_FFFF;
    exp_q.delete();
    push_expected(map_q);
    point_ready = 1'b1;
    pulse_start();
    repeat (6) @(posedge clk);
    #1;
    check("pre_reset_busy", {31'b0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 0);
    check("arst_done", {31'b0, done}, 0);
    check("arst_addr", {13'b0, read_addr}, 0);
    check("arst_pvalid", {31'b0, point_valid}, 0);
    check("arst_point", {13'b0, point_y, point_x}, 0);
    check("arst_count", {13'b0, edge_count}, 0);
    check("arst_bbox", {bbox_min_x[7:0], bbox_max_x[7:0], 7'b0, bbox_min_y, 8'(bbox_max_y)}, 0);
    check("arst_bbox_valid", {31'b0, bbox_valid}, 0);
    #20 rst_n = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
